// File: rtl/clk_ui_pkg.sv
// Shared encodings and BCD limits for the clock user-interface blocks.
// Pure declarations: no latency and no flow control.
package clk_ui_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    FLD_HOUR = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_SEC  = 2'd2
  } fld_t;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> one-cycle press pulse: 2-flop sync, stable-level counter, rising-edge detect.
// Latency 2 + DEB_CYCLES + 1 cycles from raw edge to pulse; no backpressure, pulse is fire-and-forget.
module btn_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic        level_d;
  logic [19:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any return to the accepted level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= DEB_CYCLES - 20'd1) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/set_mode_ctrl.sv
// Three-button UI controller: run / set-time / set-alarm modes with BCD field editing.
// Edits land one cycle after a debounced press; set_time_finish is a one-cycle strobe with no handshake.
module set_mode_ctrl
  import clk_ui_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter logic [23:0] BLINK_DIV  = 24'd6250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [3:0] cur_hour_shi,
  input  logic [3:0] cur_hour_ge,
  input  logic [3:0] cur_min_shi,
  input  logic [3:0] cur_min_ge,
  output logic       set_time_finish,
  output logic [3:0] set_hour_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_sec_ge,
  output logic       clock_en,
  output logic [3:0] clock_hour_shi,
  output logic [3:0] clock_hour_ge,
  output logic [3:0] clock_min_shi,
  output logic [3:0] clock_min_ge,
  output logic [1:0] mode,
  output logic [1:0] edit_field,
  output logic       blink
);

  logic        p_mode;
  logic        p_next;
  logic        p_inc;
  mode_t       state;
  fld_t        fld;
  logic [7:0]  set_hour;
  logic [7:0]  set_min;
  logic [7:0]  set_sec;
  logic [7:0]  alm_hour;
  logic [7:0]  alm_min;
  logic [23:0] blink_cnt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .press(p_mode));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (.clk(clk), .rst_n(rst_n), .btn(btn_next), .press(p_next));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc  (.clk(clk), .rst_n(rst_n), .btn(btn_inc),  .press(p_inc));

  // Wraps to 00 at the field limit; out-of-range input also wraps rather than running away.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim)
      return 8'h00;
    else if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= MODE_RUN;
      fld             <= FLD_HOUR;
      set_hour        <= 8'h00;
      set_min         <= 8'h00;
      set_sec         <= 8'h00;
      alm_hour        <= 8'h00;
      alm_min         <= 8'h00;
      clock_en        <= 1'b0;
      set_time_finish <= 1'b0;
    end else begin
      set_time_finish <= 1'b0;
      if (p_mode) begin
        fld <= FLD_HOUR;
        case (state)
          MODE_RUN: begin
            state    <= MODE_SET_TIME;
            set_hour <= {cur_hour_shi, cur_hour_ge};
            set_min  <= {cur_min_shi, cur_min_ge};
            set_sec  <= 8'h00;
          end
          MODE_SET_TIME: begin
            state           <= MODE_SET_ALARM;
            set_time_finish <= 1'b1;
          end
          default: state <= MODE_RUN;
        endcase
      end else if (p_next) begin
        case (state)
          MODE_SET_TIME:  fld <= (fld == FLD_HOUR) ? FLD_MIN : (fld == FLD_MIN) ? FLD_SEC : FLD_HOUR;
          MODE_SET_ALARM: fld <= (fld == FLD_HOUR) ? FLD_MIN : FLD_HOUR;
          default: ;
        endcase
      end else if (p_inc) begin
        case (state)
          MODE_RUN: clock_en <= ~clock_en;
          MODE_SET_TIME: begin
            case (fld)
              FLD_HOUR: set_hour <= bcd_inc(set_hour, HOUR_MAX);
              FLD_MIN:  set_min  <= bcd_inc(set_min, MINSEC_MAX);
              default:  set_sec  <= bcd_inc(set_sec, MINSEC_MAX);
            endcase
          end
          default: begin
            if (fld == FLD_HOUR)
              alm_hour <= bcd_inc(alm_hour, HOUR_MAX);
            else
              alm_min <= bcd_inc(alm_min, MINSEC_MAX);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state == MODE_RUN) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt >= BLINK_DIV - 24'd1) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  assign mode           = state;
  assign edit_field     = fld;
  assign set_hour_shi   = set_hour[7:4];
  assign set_hour_ge    = set_hour[3:0];
  assign set_min_shi    = set_min[7:4];
  assign set_min_ge     = set_min[3:0];
  assign set_sec_shi    = set_sec[7:4];
  assign set_sec_ge     = set_sec[3:0];
  assign clock_hour_shi = alm_hour[7:4];
  assign clock_hour_ge  = alm_hour[3:0];
  assign clock_min_shi  = alm_min[7:4];
  assign clock_min_ge   = alm_min[3:0];

endmodule
